// File: rtl/risc_pkg.sv
// Shared RV32I definitions: instruction formats, base opcodes and the
// immediate ranges each format can carry.
package risc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4095;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048575;

  function automatic logic imm_in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational packer: turns a field-level descriptor into an RV32I word
// and reports whether the immediate is representable in that format.
module instr_encode
  import risc_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_ok
);

  instr_fmt_t fmt_e;
  assign fmt_e = instr_fmt_t'(fmt);

  // Branch and jump offsets are halfword aligned, so imm[0] is never encoded.
  always_comb begin
    word   = '0;
    imm_ok = 1'b0;
    case (fmt_e)
      FMT_R: begin
        word   = {funct7, rs2, rs1, funct3, rd, opcode};
        imm_ok = 1'b1;
      end
      FMT_I: begin
        word   = {imm[11:0], rs1, funct3, rd, opcode};
        imm_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_S: begin
        word   = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        imm_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
      end
      FMT_B: begin
        word   = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        imm_ok = imm_in_range(imm, IMM13_MIN, IMM13_MAX) && !imm[0];
      end
      FMT_U: begin
        word   = {imm[31:12], rd, opcode};
        imm_ok = (imm[11:0] == 12'd0);
      end
      FMT_J: begin
        word   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        imm_ok = imm_in_range(imm, IMM21_MIN, IMM21_MAX) && !imm[0];
      end
      default: begin
        word   = '0;
        imm_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Session-based instruction loader: encodes descriptors and streams legal
// words into instruction memory at consecutive word addresses.
module imem_loader
  import risc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_last,
  input  logic [2:0]               in_fmt,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [31:0]              in_imm,
  output logic                     mem_we,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   words,
  output logic                     err_imm,
  output logic                     err_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state;
  logic [31:0] enc_word;
  logic        imm_ok;
  logic        accept;
  logic        wr_done;
  logic        full;
  logic        load_word;
  logic [CW:0] occupancy;

  instr_encode u_encode (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .word   (enc_word),
    .imm_ok (imm_ok)
  );

  // A word sitting in the output register already owns a memory slot.
  assign occupancy = {1'b0, words} + {{CW{1'b0}}, mem_we};
  assign full      = (occupancy >= DEPTH_W);
  assign in_ready  = (state == ST_LOAD) && (!mem_we || mem_ready);
  assign accept    = in_valid && in_ready;
  assign wr_done   = mem_we && mem_ready;
  assign load_word = accept && imm_ok && !full;
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= BASE_ADDR;
      mem_wdata <= '0;
      words     <= '0;
      err_imm   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (wr_done) begin
        mem_addr <= mem_addr + 32'd4;
        words    <= words + CW'(1);
      end
      if (load_word) begin
        mem_wdata <= enc_word;
        mem_we    <= 1'b1;
      end else if (wr_done) begin
        mem_we <= 1'b0;
      end
      if (accept && !imm_ok) err_imm <= 1'b1;
      if (accept && imm_ok && full) err_ovf <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            mem_addr <= BASE_ADDR;
            words    <= '0;
            err_imm  <= 1'b0;
            err_ovf  <= 1'b0;
          end
        end
        ST_LOAD:  if (accept && in_last) state <= ST_FLUSH;
        ST_FLUSH: if (!mem_we || mem_ready) state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule
